// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants, S-box and column mixing.
package aes_pkg;

  typedef enum logic [1:0] {LOAD, ROUND, OUT} aes_fsm_e;

  // Indexed by round number 1..10; unused slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column packed with row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round plus the matching key-schedule step.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic [7:0]   i_rcon,
  input  logic         i_last,
  output logic [127:0] o_state,
  output logic [127:0] o_rkey
);
  // Byte b of the column-major block lives at element [15-b].
  logic [15:0][7:0] w_in, w_sb, w_sr;
  logic [127:0]     w_srf, w_mcf;
  logic [3:0][31:0] w_kw, w_nk;
  logic [31:0]      w_rot, w_tmp;

  assign w_in = i_state;
  assign w_kw = i_rkey;

  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign w_sb[b] = sbox(w_in[b]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[15-(4*c+r)] = w_sb[15-(4*((c+r)%4)+r)];
    end
    assign w_mcf[127-32*c -: 32] = i_last ? w_srf[127-32*c -: 32]
                                          : mix_column(w_srf[127-32*c -: 32]);
  end
  assign w_srf = w_sr;

  // w_kw[3] is word 0 of the round key, w_kw[0] is word 3.
  assign w_rot = {w_kw[0][23:0], w_kw[0][31:24]};
  assign w_tmp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
               ^ {i_rcon, 24'h0};
  assign w_nk[3] = w_kw[3] ^ w_tmp;
  assign w_nk[2] = w_kw[2] ^ w_nk[3];
  assign w_nk[1] = w_kw[1] ^ w_nk[2];
  assign w_nk[0] = w_kw[0] ^ w_nk[1];

  assign o_rkey  = w_nk;
  assign o_state = w_mcf ^ w_nk;

endmodule

// File: rtl/aes_encrypty.sv
// Byte-serial AES-128 encryptor: 16 load cycles, 10 round cycles, 16 output cycles.
module aes_encrypty
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic [7:0] key,
  output logic [7:0] chiper,
  output logic       chiper_valid
);
  aes_fsm_e         r_fsm, w_nxt_fsm;
  logic [3:0]       r_idx, r_rnd, w_pos;
  logic [15:0][7:0] r_state, r_rkey;
  logic [127:0]     w_nxt_state, w_nxt_key;

  // Host streams are row-major, registers column-major: swap row/column halves of idx.
  assign w_pos = {r_idx[1:0], r_idx[3:2]};

  aes_round u_round (
    .i_state (r_state),
    .i_rkey  (r_rkey),
    .i_rcon  (RCON[r_rnd]),
    .i_last  (r_rnd == 4'd10),
    .o_state (w_nxt_state),
    .o_rkey  (w_nxt_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= LOAD;
    else        r_fsm <= w_nxt_fsm;
  end

  always_comb begin
    w_nxt_fsm = r_fsm;
    case (r_fsm)
      LOAD:    if (r_idx == 4'd15) w_nxt_fsm = ROUND;
      ROUND:   if (r_rnd == 4'd10) w_nxt_fsm = OUT;
      OUT:     if (r_idx == 4'd15) w_nxt_fsm = LOAD;
      default: w_nxt_fsm = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_rnd   <= '0;
      r_state <= '0;
      r_rkey  <= '0;
    end else begin
      case (r_fsm)
        LOAD: begin
          r_state[~w_pos] <= data ^ key;
          r_rkey[~w_pos]  <= key;
          r_idx           <= r_idx + 4'd1;
          if (r_idx == 4'd15) r_rnd <= 4'd1;
        end
        ROUND: begin
          r_state <= w_nxt_state;
          r_rkey  <= w_nxt_key;
          r_rnd   <= (r_rnd == 4'd10) ? 4'd0 : r_rnd + 4'd1;
        end
        OUT:     r_idx <= r_idx + 4'd1;
        default: r_idx <= '0;
      endcase
    end
  end

  assign chiper_valid = (r_fsm == OUT);
  assign chiper       = (r_fsm == OUT) ? r_state[~w_pos] : 8'h00;

endmodule

// File: tb/tb_aes_encrypty.sv
// Bench for aes_encrypty: known-answer table, random blocks vs. a reference model, reset aborts.
module tb_aes_encrypty;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data, key, chiper;
  logic       chiper_valid;
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb_ref [256];

  typedef struct {
    logic [127:0] k;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           noise;
  } vec_t;
  vec_t vecs [3];

  aes_encrypty dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .key          (key),
    .chiper       (chiper),
    .chiper_valid (chiper_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Whole-block AES-128 with a fully expanded key schedule; I/O as row-major byte streams.
  function automatic logic [127:0] ref_enc(input logic [127:0] k_rm, input logic [127:0] pt_rm);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = byte_of(pt_rm, 4*r+c);
    for (int c = 0; c < 4; c++)
      w[c] = {byte_of(k_rm, c), byte_of(k_rm, 4+c), byte_of(k_rm, 8+c), byte_of(k_rm, 12+c)};
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_ref[tmp[31:24]], sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb_ref[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = t[r][(c+r)%4];
      if (rd < 10) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            t[r][c] = gf_mul(8'h02, s[r][c]) ^ gf_mul(8'h03, s[(r+1)%4][c]) ^ s[(r+2)%4][c] ^ s[(r+3)%4][c];
        s = t;
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(4*r+c) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit noise);
    data = noise ? 8'($urandom) : 8'h00;
    key  = noise ? 8'($urandom) : 8'h00;
  endtask

  // Entered #1 after an edge whose successor is a LOAD capture edge.
  task automatic load16(input logic [127:0] k, input logic [127:0] pt);
    for (int i = 0; i < 16; i++) begin
      data = byte_of(pt, i);
      key  = byte_of(k, i);
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_blk(input logic [127:0] ct, input bit noise);
    for (int j = 1; j <= 10; j++) begin
      drive(noise);
      @(posedge clk); #1;
      if (j < 10) check("round_valid_low", 8'(chiper_valid), 8'h00);
    end
    for (int k = 0; k < 16; k++) begin
      check("out_valid", 8'(chiper_valid), 8'h01);
      check($sformatf("out_byte%0d", k), chiper, byte_of(ct, k));
      if (k < 15) begin
        drive(noise);
        @(posedge clk); #1;
      end
    end
    drive(noise);
    @(posedge clk); #1;
    check("post_valid_low", 8'(chiper_valid), 8'h00);
    check("post_byte_zero", chiper, 8'h00);
  endtask

  initial begin
    logic [127:0] rk, rp;
    rst_n = 1'b0;
    data  = 8'h00;
    key   = 8'h00;
    build_sbox();

    vecs[0] = '{k: 128'h2b28ab097eaef7cf15d2154f16a6883c, pt: 128'h328831e0435a3137f6309807a88da234,
                ct: 128'h3902dc1925dc116a8409850b1dfb9732, noise: 1'b0};
    vecs[1] = '{k: 128'h0004080c0105090d02060a0e03070b0f, pt: 128'h004488cc115599dd2266aaee3377bbff,
                ct: 128'h696ad870c47bcdb4e004b7c5d830805a, noise: 1'b1};
    vecs[2] = '{k: 128'h0, pt: 128'h0,
                ct: 128'h66ef88cae98a4c344b2cfa2bd43b592e, noise: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_byte", chiper, 8'h00);
    check("reset_valid", 8'(chiper_valid), 8'h00);
    rst_n = 1'b1;

    // Known answers, back to back with no idle cycle between blocks.
    for (int v = 0; v < 3; v++) begin
      load16(vecs[v].k, vecs[v].pt);
      finish_blk(vecs[v].ct, vecs[v].noise);
    end

    // Random blocks against the model, with noise on the inputs while busy.
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      load16(rk, rp);
      finish_blk(ref_enc(rk, rp), 1'b1);
    end

    // Reset during round 5 aborts the block.
    load16(vecs[0].k, vecs[0].pt);
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_round_byte", chiper, 8'h00);
    check("rst_round_valid", 8'(chiper_valid), 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_valid", 8'(chiper_valid), 8'h00);
    end
    rst_n = 1'b1;
    load16(vecs[0].k, vecs[0].pt);
    finish_blk(vecs[0].ct, 1'b0);

    // Reset in the middle of the output phase.
    load16(vecs[1].k, vecs[1].pt);
    for (int j = 1; j <= 13; j++) begin
      drive(1'b0);
      @(posedge clk); #1;
    end
    check("mid_out_valid", 8'(chiper_valid), 8'h01);
    check("mid_out_byte3", chiper, byte_of(vecs[1].ct, 3));
    rst_n = 1'b0;
    #1;
    check("rst_out_byte", chiper, 8'h00);
    check("rst_out_valid", 8'(chiper_valid), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    load16(rk, rp);
    finish_blk(ref_enc(rk, rp), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
